// File: rtl/parity_pkg.sv
// Shared types, constants and helpers for the multi-lane serial parity checker.
package parity_pkg;

  // Framing state: collecting data beats, or waiting for the parity beat.
  typedef enum logic {
    S_DATA  = 1'b0,
    S_CHECK = 1'b1
  } state_e;

  // Width of the optional erroneous-frame counter.
  localparam int unsigned ERR_CNT_W = 16;

  // Parity bit a lane should receive: the data XOR for even mode, its inverse for odd mode.
  function automatic logic even_odd_expect(input logic acc, input logic mode);
    return acc ^ mode;
  endfunction

endpackage

// File: rtl/parity_lane_acc.sv
// One serial lane: running-parity accumulator plus parity-beat compare.
// Framing control (which beat is data, which is parity) comes from the shared top-level FSM.
module parity_lane_acc
  import parity_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_data_beat,
  input  logic i_par_beat,
  input  logic i_mode,
  input  logic i_bit,
  output logic o_acc,
  output logic o_err,
  output logic o_mismatch
);

  logic r_acc;
  logic r_err;
  logic w_mismatch;

  // Mismatch of the bit currently presented, meaningful only on a parity beat.
  assign w_mismatch = i_bit ^ even_odd_expect(r_acc, i_mode);

  // Accumulate data bits; on the parity beat latch the verdict and restart the accumulator.
  // The verdict is left untouched by clear so the last completed frame stays visible.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= 1'b0;
      r_err <= 1'b0;
    end else if (i_clear) begin
      r_acc <= 1'b0;
    end else if (i_data_beat) begin
      r_acc <= r_acc ^ i_bit;
    end else if (i_par_beat) begin
      r_err <= w_mismatch;
      r_acc <= 1'b0;
    end
  end

  assign o_acc      = r_acc;
  assign o_err      = r_err;
  assign o_mismatch = w_mismatch;

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-lane serial parity checker. WIDTH lanes share one framing FSM; every frame is
// FRAME_LEN data beats followed by one parity beat, checked in even or odd mode.
// Optional build macro: PARITY_FRAME_ERR_CNT_EN adds a saturating erroneous-frame counter
// on output err_count.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             odd_mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bits,
  output logic [WIDTH-1:0] running_parity,
  output logic             busy,
  output logic             frame_done,
  output logic [WIDTH-1:0] parity_err
`ifdef PARITY_FRAME_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_mode;
  logic             r_frame_done;

  logic             w_data_beat;
  logic             w_par_beat;
  logic [WIDTH-1:0] w_mismatch;

  // clear outranks in_valid, so a beat presented alongside clear is never accepted.
  assign w_data_beat = in_valid & ~clear & (r_state == S_DATA);
  assign w_par_beat  = in_valid & ~clear & (r_state == S_CHECK);

  // Framing FSM: bit counter, frame parity mode capture and the frame_done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_DATA;
      r_bit_cnt    <= '0;
      r_mode       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_state      <= S_DATA;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // Pulse only in the cycle after a parity beat; any other cycle drops it.
      r_frame_done <= w_par_beat;
      case (r_state)
        S_DATA: begin
          if (in_valid) begin
            // Mode is frozen at the first data beat; later odd_mode changes wait a frame.
            if (r_bit_cnt == '0) begin
              r_mode <= odd_mode;
            end
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_DATA_CNT) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (in_valid) begin
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        default: begin
          r_state   <= S_DATA;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // Per-lane accumulators; all lanes follow the same beat qualifiers.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    parity_lane_acc u_lane (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_clear    (clear),
      .i_data_beat(w_data_beat),
      .i_par_beat (w_par_beat),
      .i_mode     (r_mode),
      .i_bit      (in_bits[g]),
      .o_acc      (running_parity[g]),
      .o_err      (parity_err[g]),
      .o_mismatch (w_mismatch[g])
    );
  end

  assign busy       = (r_bit_cnt != '0);
  assign frame_done = r_frame_done;

`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  // Count frames with any lane in error; the new value is visible alongside frame_done.
  // Only reset clears it, so aborted frames never disturb the statistic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_par_beat && (|w_mismatch) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_mismatch;
  assign w_unused_mismatch = ^w_mismatch;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a frame-level reference model.
module tb_parity_frame_checker;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned FRAME_LEN = 8;

  logic             clock;
  logic             reset;
  logic             clear;
  logic             odd_mode;
  logic             in_valid;
  logic [WIDTH-1:0] in_bits;
  logic [WIDTH-1:0] running_parity;
  logic             busy;
  logic             frame_done;
  logic [WIDTH-1:0] parity_err;
`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [15:0]      err_count;
`endif

  parity_frame_checker #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .odd_mode      (odd_mode),
    .in_valid      (in_valid),
    .in_bits       (in_bits),
    .running_parity(running_parity),
    .busy          (busy),
    .frame_done    (frame_done),
    .parity_err    (parity_err)
`ifdef PARITY_FRAME_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the data beats of the current frame are kept verbatim in a queue.
  logic [WIDTH-1:0] m_beats[$];
  logic             m_mode;
  logic             m_done;
  logic [WIDTH-1:0] m_err;
  int unsigned      m_errcnt;

  typedef struct {
    logic             clr;
    logic             vld;
    logic             odd;
    logic [WIDTH-1:0] bits;
    logic [WIDTH-1:0] exp_rp;
    logic             exp_busy;
    logic             exp_done;
    logic [WIDTH-1:0] exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] frame_xor();
    logic [WIDTH-1:0] x = '0;
    foreach (m_beats[i]) x ^= m_beats[i];
    return x;
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_mode   = 1'b0;
    m_done   = 1'b0;
    m_err    = '0;
    m_errcnt = 0;
  endtask

  // One clock edge of the frame-level behaviour.
  task automatic model_edge(input logic c, input logic v, input logic o,
                            input logic [WIDTH-1:0] b);
    m_done = 1'b0;
    if (c) begin
      m_beats.delete();
    end else if (v) begin
      if (m_beats.size() == FRAME_LEN) begin
        m_err  = b ^ frame_xor() ^ {WIDTH{m_mode}};
        m_done = 1'b1;
        if (m_err != '0 && m_errcnt < 32'hFFFF) m_errcnt++;
        m_beats.delete();
      end else begin
        if (m_beats.size() == 0) m_mode = o;
        m_beats.push_back(b);
      end
    end
  endtask

  task automatic step(input logic c, input logic v, input logic o, input logic [WIDTH-1:0] b);
    clear    = c;
    in_valid = v;
    odd_mode = o;
    in_bits  = b;
    @(posedge clock);
    #1;
    model_edge(c, v, o, b);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rp"},   32'(running_parity), 32'(frame_xor()));
    check({tag, "_busy"}, 32'(busy),           32'(m_beats.size() != 0));
    check({tag, "_done"}, 32'(frame_done),     32'(m_done));
    check({tag, "_err"},  32'(parity_err),     32'(m_err));
`ifdef PARITY_FRAME_ERR_CNT_EN
    check({tag, "_cnt"},  32'(err_count),      m_errcnt);
`endif
  endtask

  task automatic add(input logic c, input logic v, input logic o, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] rp, input logic bz, input logic dn,
                     input logic [WIDTH-1:0] er);
    vecs.push_back('{clr: c, vld: v, odd: o, bits: b, exp_rp: rp, exp_busy: bz,
                     exp_done: dn, exp_err: er});
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    odd_mode = 1'b0;
    in_valid = 1'b0;
    in_bits  = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_rp",   32'(running_parity), 32'h0);
    check("reset_busy", 32'(busy),           32'h0);
    check("reset_done", 32'(frame_done),     32'h0);
    check("reset_err",  32'(parity_err),     32'h0);
    reset = 1'b0;

    // Even frame: eight beats of 0001 then parity 0110 -> lanes 1 and 2 wrong.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1, 0, 4'b0000);
    add(0, 1, 0, 4'b0110, 4'b0000, 0, 1, 4'b0110);
    add(0, 0, 0, 4'b1010, 4'b0000, 0, 0, 4'b0110);
    // Odd frame of zeros with correct parity 1111.
    for (int i = 0; i < 8; i++) add(0, 1, 1, 4'b0000, 4'b0000, 1, 0, 4'b0110);
    add(0, 1, 1, 4'b1111, 4'b0000, 0, 1, 4'b0000);
    // Same odd frame, odd_mode dropped after the first beat, parity 0000 -> all lanes wrong.
    add(0, 1, 1, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 1, 4'b1111);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].vld, vecs[i].odd, vecs[i].bits);
      check($sformatf("vec%0d_rp", i),   32'(running_parity), 32'(vecs[i].exp_rp));
      check($sformatf("vec%0d_busy", i), 32'(busy),           32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(frame_done),     32'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i),  32'(parity_err),     32'(vecs[i].exp_err));
    end

    // Stalls with valid pattern 1,0,0 and a new frame's first beat in the frame_done cycle.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i <= FRAME_LEN; i++) begin
        step(0, 1, f[0], 4'(i * 3 + f));
        check_model($sformatf("b2b%0d_%0d", f, i));
        if (f == 0 || i != FRAME_LEN) begin
          step(0, 0, 0, 4'hF);
          check_model($sformatf("b2b%0d_%0ds1", f, i));
          step(0, 0, 1, 4'h5);
          check_model($sformatf("b2b%0d_%0ds2", f, i));
        end
      end
    end
    step(0, 1, 0, 4'b1001);
    check_model("b2b_next");

    // clear with in_valid at beat 5, then a full clean frame of 9 beats.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 4'(i + 1));
    step(1, 1, 0, 4'b1111);
    check("clear_busy", 32'(busy), 32'h0);
    check("clear_rp", 32'(running_parity), 32'h0);
    check_model("clear");
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 4'(i * 5 + 2));
      check_model($sformatf("postclr%0d", i));
    end

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           WIDTH'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-frame, asserted away from any clock edge.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1111);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_rp",   32'(running_parity), 32'h0);
    check("arst_busy", 32'(busy),           32'h0);
    check("arst_done", 32'(frame_done),     32'h0);
    check("arst_err",  32'(parity_err),     32'h0);
    reset = 1'b0;
    model_reset();
    step(0, 1, 0, 4'b0011);
    check_model("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
